fifo_stream_reader: RTL and testbench

Read-side drain controller for the single-clock synchronous FIFO. It issues pops against the FIFO's registered-output read port, absorbing the one-cycle read latency. It presents the popped words to a downstream consumer as a valid/ready stream at full throughput of one word per cycle. It sits between the FIFO's read port and any stream consumer.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_skid_buf.sv | 76 +++++++
 rtl/fifo_stream_reader.sv | 80 ++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and occupancy encoding for the FIFO read-side stream logic.
package fifo_pkg;

    localparam int unsigned FIFO_BITWIDTH = 8;
    localparam int unsigned BEATCNT_W     = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid word store; head is always the oldest word and the one presented.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned Width = FIFO_BITWIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             capture_i,
    input  logic [Width-1:0] cap_data_i,
    input  logic             fire_i,
    output logic [Width-1:0] head_o,
    output logic             valid_o,
    output logic [1:0]       occ_o
);

    occ_e             occ_q;
    logic             valid_q;
    logic [Width-1:0] head_q;
    logic [Width-1:0] skid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (clr_i) begin
            // head_q is deliberately kept so the output word does not change on a flush
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (capture_i) begin
                        head_q  <= cap_data_i;
                        occ_q   <= OCC_ONE;
                        valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (fire_i && capture_i) begin
                        head_q <= cap_data_i;
                    end else if (fire_i) begin
                        occ_q   <= OCC_EMPTY;
                        valid_q <= 1'b0;
                    end else if (capture_i) begin
                        skid_q <= cap_data_i;
                        occ_q  <= OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    // Credit gating means a capture here always coincides with a fire
                    if (fire_i) begin
                        head_q <= skid_q;
                        if (capture_i) begin
                            skid_q <= cap_data_i;
                        end else begin
                            occ_q <= OCC_ONE;
                        end
                    end
                end
                default: begin
                    occ_q   <= OCC_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream at one word per cycle.
// Defining FIFO_RD_STATS_EN adds the oBeatCnt fire counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned BITWIDTH = FIFO_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClr,
    input  logic                iFifoEmpty,
    input  logic [BITWIDTH-1:0] iFifoData,
    output logic                oFifoEnR,
    output logic                oValid,
    output logic [BITWIDTH-1:0] oData,
    input  logic                iReady,
    output logic [1:0]          oOcc
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [BEATCNT_W-1:0] oBeatCnt
`endif
);

    logic       inflight_q;
    logic       inflight_d;
    logic       fire;
    logic       has_credit;
    logic [2:0] committed;
    logic [1:0] occ;
    logic       valid;

    assign fire = valid & iReady;

    // Pop only while occupied + in-flight words, less this cycle's fire, stay below two
    assign committed  = {1'b0, occ} + {2'b00, inflight_q};
    assign has_credit = committed < (3'd2 + {2'b00, fire});

    assign oFifoEnR   = ~iFifoEmpty & ~iClr & ~iRst & has_credit;
    assign inflight_d = oFifoEnR;

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf #(
        .Width (BITWIDTH)
    ) u_skid_buf (
        .clk_i      (iClk),
        .rst_i      (iRst),
        .clr_i      (iClr),
        .capture_i  (inflight_q),
        .cap_data_i (iFifoData),
        .fire_i     (fire),
        .head_o     (oData),
        .valid_o    (valid),
        .occ_o      (occ)
    );

    assign oValid = valid;
    assign oOcc   = occ;

`ifdef FIFO_RD_STATS_EN
    logic [BEATCNT_W-1:0] beat_cnt_q;

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            beat_cnt_q <= '0;
        end else if (fire) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    assign oBeatCnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a small registered-read FIFO model.
module tb_fifo_stream_reader;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iClr;
    logic       iFifoEmpty;
    logic [7:0] iFifoData = 8'h00;
    logic       oFifoEnR;
    logic       oValid;
    logic [7:0] oData;
    logic       iReady;
    logic [1:0] oOcc;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] oBeatCnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'h00;
    logic [7:0] rd_ptr = 8'h00;
    logic [7:0] out_q [$];

    always #5 iClk = ~iClk;

    fifo_stream_reader #(
        .BITWIDTH (8)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iClr       (iClr),
        .iFifoEmpty (iFifoEmpty),
        .iFifoData  (iFifoData),
        .oFifoEnR   (oFifoEnR),
        .oValid     (oValid),
        .oData      (oData),
        .iReady     (iReady),
        .oOcc       (oOcc)
`ifdef FIFO_RD_STATS_EN
        ,
        .oBeatCnt   (oBeatCnt)
`endif
    );

    assign iFifoEmpty = (wr_ptr == rd_ptr);

    // FIFO read port model plus a log of every word the consumer accepts
    always @(posedge iClk) begin
        if (iClr) begin
            rd_ptr <= wr_ptr;
        end else if (oFifoEnR && !iFifoEmpty) begin
            iFifoData <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
        if (oValid && iReady && !iRst) out_q.push_back(oData);
    end

    task automatic tick;
        @(negedge iClk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset;
        iRst = 1'b1; iClr = 1'b0; iReady = 1'b0;
        tick; tick;
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", oValid); end
        total++; if (oData !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", oData); end
        total++; if (oOcc !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", oOcc); end
        total++; if (oFifoEnR !== 1'b0) begin bad++; $display("FAIL reset_enr got=%b want=0", oFifoEnR); end
        iRst = 1'b0;
        tick;
    endtask

    task automatic test_stream;
        logic [7:0] exp_d [0:3];
        logic exp_en, exp_v;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
        iReady = 1'b1;
        for (int i = 0; i < 4; i++) push(exp_d[i]);
        #1;
        for (int c = 0; c < 7; c++) begin
            exp_en = (c < 4);
            exp_v  = (c >= 2 && c <= 5);
            total++;
            if (oFifoEnR !== exp_en) begin
                bad++; $display("FAIL stream_enr c=%0d got=%b want=%b", c, oFifoEnR, exp_en);
            end
            total++;
            if (oValid !== exp_v) begin
                bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, oValid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (oData !== exp_d[c-2]) begin
                    bad++; $display("FAIL stream_data c=%0d got=%h want=%h", c, oData, exp_d[c-2]);
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] rd_start;
        iReady = 1'b0;
        rd_start = rd_ptr;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        repeat (4) tick;
        total++; if (oOcc !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d want=2", oOcc); end
        total++; if (oFifoEnR !== 1'b0) begin bad++; $display("FAIL bp_enr got=%b want=0", oFifoEnR); end
        total++;
        if (8'(rd_ptr - rd_start) !== 8'd2) begin
            bad++; $display("FAIL bp_pops got=%0d want=2", 8'(rd_ptr - rd_start));
        end
        iReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (oValid !== 1'b1 || oData !== 8'h30 + 8'(i)) begin
                bad++;
                $display("FAIL bp_drain i=%0d got=%b/%h want=1/%h", i, oValid, oData, 8'h30 + 8'(i));
            end
            tick;
        end
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b want=0", oValid); end
    endtask

    task automatic test_toggle;
        int start;
        start = out_q.size();
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        for (int c = 0; c < 30; c++) begin
            iReady = (c % 2 == 0);
            tick;
        end
        iReady = 1'b0;
        total++;
        if (out_q.size() - start != 8) begin
            bad++; $display("FAIL toggle_count got=%0d want=8", out_q.size() - start);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (start + i >= out_q.size()) begin
                bad++; $display("FAIL toggle_word i=%0d got=none want=%h", i, 8'h40 + 8'(i));
            end else if (out_q[start+i] !== 8'h40 + 8'(i)) begin
                bad++; $display("FAIL toggle_word i=%0d got=%h want=%h", i, out_q[start+i], 8'h40 + 8'(i));
            end
        end
    endtask

    task automatic test_clear;
        int start;
        iReady = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        repeat (3) tick;
        total++; if (oOcc !== 2'd1) begin bad++; $display("FAIL clr_pre_occ got=%0d want=1", oOcc); end
        total++; if (oData !== 8'h61) begin bad++; $display("FAIL clr_pre_data got=%h want=61", oData); end
        iClr = 1'b1;
        iReady = 1'b0;
        #1;
        total++; if (oFifoEnR !== 1'b0) begin bad++; $display("FAIL clr_enr got=%b want=0", oFifoEnR); end
        start = out_q.size();
        tick;
        iClr = 1'b0;
        total++; if (oValid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", oValid); end
        total++; if (oOcc !== 2'd0) begin bad++; $display("FAIL clr_occ got=%0d want=0", oOcc); end
        total++; if (oData !== 8'h61) begin bad++; $display("FAIL clr_data_hold got=%h want=61", oData); end
        push(8'hA5);
        push(8'h5A);
        iReady = 1'b1;
        repeat (8) tick;
        total++;
        if (out_q.size() - start != 2) begin
            bad++; $display("FAIL clr_after_count got=%0d want=2", out_q.size() - start);
        end else if (out_q[start] !== 8'hA5 || out_q[start+1] !== 8'h5A) begin
            bad++; $display("FAIL clr_after_words got=%h,%h want=a5,5a", out_q[start], out_q[start+1]);
        end
    endtask

    task automatic test_mid_reset;
        int start;
        iReady = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
        repeat (4) tick;
        total++; if (oOcc !== 2'd2) begin bad++; $display("FAIL mrst_pre_occ got=%0d want=2", oOcc); end
        iRst = 1'b1;
        #1;
        total++; if (oFifoEnR !== 1'b0) begin bad++; $display("FAIL mrst_enr got=%b want=0", oFifoEnR); end
        start = out_q.size();
        tick;
        total++;
        if (oValid !== 1'b0 || oData !== 8'h00 || oOcc !== 2'd0) begin
            bad++; $display("FAIL mrst_state got=%b/%h/%0d want=0/00/0", oValid, oData, oOcc);
        end
        iRst = 1'b0;
        iReady = 1'b1;
        repeat (14) tick;
        total++;
        if (out_q.size() - start != 6) begin
            bad++; $display("FAIL mrst_count got=%0d want=6", out_q.size() - start);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (out_q[start+i] !== 8'h72 + 8'(i)) begin
                    bad++; $display("FAIL mrst_word i=%0d got=%h want=%h", i, out_q[start+i], 8'h72 + 8'(i));
                end
            end
        end
    endtask

`ifdef FIFO_RD_STATS_EN
    task automatic test_stats;
        iReady = 1'b1;
        iClr = 1'b1;
        tick;
        iClr = 1'b0;
        total++; if (oBeatCnt !== 16'd0) begin bad++; $display("FAIL stats_init got=%0d want=0", oBeatCnt); end
        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
        repeat (15) tick;
        total++; if (oBeatCnt !== 16'd10) begin bad++; $display("FAIL stats_ten got=%0d want=10", oBeatCnt); end
        iClr = 1'b1;
        tick;
        iClr = 1'b0;
        total++; if (oBeatCnt !== 16'd0) begin bad++; $display("FAIL stats_clr got=%0d want=0", oBeatCnt); end
        for (int i = 0; i < 3; i++) push(8'h90 + 8'(i));
        repeat (8) tick;
        total++; if (oBeatCnt !== 16'd3) begin bad++; $display("FAIL stats_three got=%0d want=3", oBeatCnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_toggle;
        test_clear;
        test_mid_reset;
`ifdef FIFO_RD_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
